shift_reg_sequencer: RTL

- Command-driven controller for the 4-bit universal shift register. It drives the register's ENB, DIR, S_IN, MODO and D pins.
- It sequences an optional parallel load, then N shift or rotate cycles, then a result capture.
- Returns the final Q and the serially shifted-out bits to the requester through a valid/ready command and done/result interface.
- Replaces hand-written CLK/MODO stimulus with a reusable scheduler.

---
 rtl/shift_reg_sequencer_pkg.sv | 26 ++
 rtl/shift_reg_sequencer_shift_count.sv | 39 +++
 rtl/shift_reg_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/shift_reg_sequencer_pkg.sv
// Shared constants for the universal shift-register sequencer: register modes,
// enable levels, FSM state encoding and default sizing.
package shift_reg_sequencer_pkg;

    localparam int unsigned MAX_SHIFT_DEF = 8;
    localparam int unsigned CNT_W_DEF     = 4;

    localparam logic [1:0] MODO_00 = 2'b00;  // shift
    localparam logic [1:0] MODO_01 = 2'b01;  // rotate
    localparam logic [1:0] MODO_10 = 2'b10;  // parallel load
    localparam logic [1:0] MODO_11 = 2'b11;  // hold

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SHIFT  = 3'd2;
    localparam logic [2:0] ST_SETTLE = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;

    function automatic logic [1:0] shift_modo(input logic rot);
        return rot ? MODO_01 : MODO_00;
    endfunction

endpackage

// File: rtl/shift_reg_sequencer_shift_count.sv
// Shift-cycle counter: cleared outside the shift phase, flags the final cycle.
module shift_reg_sequencer_shift_count
    import shift_reg_sequencer_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_c = (cnt_q + CNT_W'(1)) >= limit_i;

endmodule

// File: rtl/shift_reg_sequencer.sv
// Command-driven sequencer for a 4-bit universal shift register: optional load,
// N shift/rotate cycles, then capture of Q and the shifted-out serial bits.
module shift_reg_sequencer
    import shift_reg_sequencer_pkg::*;
#(
    parameter int unsigned MAX_SHIFT = MAX_SHIFT_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CMD_VALID,
    output logic                 CMD_READY,
    input  logic                 CMD_LOAD,
    input  logic                 CMD_ROT,
    input  logic                 CMD_DIR,
    input  logic [CNT_W-1:0]     CMD_COUNT,
    input  logic [3:0]           CMD_DATA,
    input  logic [MAX_SHIFT-1:0] CMD_SER,
    output logic                 ENB,
    output logic                 DIR,
    output logic                 S_IN,
    output logic [1:0]           MODO,
    output logic [3:0]           D,
    input  logic [3:0]           Q,
    input  logic                 S_OUT,
    output logic                 DONE,
    output logic [3:0]           RES_Q,
    output logic [MAX_SHIFT-1:0] RES_SER
);

    localparam logic [MAX_SHIFT-1:0] ONE_HOT0 = {{(MAX_SHIFT-1){1'b0}}, 1'b1};

    logic [2:0]           state_q, state_d;
    logic                 rot_q, rot_d, dir_q, dir_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [3:0]           data_q, data_d;
    logic [MAX_SHIFT-1:0] ser_q, ser_d;

    logic                 ready_q, ready_d, enb_q, enb_d, pdir_q, pdir_d;
    logic                 s_in_q, s_in_d, done_q, done_d;
    logic [1:0]           modo_q, modo_d;
    logic [3:0]           d_q, d_d, res_q_q, res_q_d;
    logic [MAX_SHIFT-1:0] res_ser_q, res_ser_d;

    logic                 accept_c;
    logic [CNT_W-1:0]     count_sat_c;
    logic [CNT_W-1:0]     cnt_c;
    logic                 last_c;
    logic [CNT_W-1:0]     shift_idx_c;

    assign accept_c    = CMD_VALID && ready_q;
    assign count_sat_c = (32'(CMD_COUNT) > MAX_SHIFT) ? CNT_W'(MAX_SHIFT) : CMD_COUNT;

    shift_reg_sequencer_shift_count #(
        .CNT_W (CNT_W)
    ) u_shift_count (
        .clk     (CLK),
        .rst     (RST),
        .clr_i   (state_q != ST_SHIFT),
        .inc_i   (state_q == ST_SHIFT),
        .limit_i (count_q),
        .cnt_o   (cnt_c),
        .last_c  (last_c)
    );

    // Outputs are decoded from the next state so they line up with it on the same edge.
    always_comb begin
        state_d     = state_q;
        rot_d       = rot_q;
        dir_d       = dir_q;
        count_d     = count_q;
        data_d      = data_q;
        ser_d       = ser_q;
        ready_d     = LOW;
        enb_d       = LOW;
        pdir_d      = LOW;
        s_in_d      = LOW;
        done_d      = LOW;
        modo_d      = MODO_11;
        d_d         = '0;
        res_q_d     = res_q_q;
        res_ser_d   = res_ser_q;
        shift_idx_c = (state_q == ST_SHIFT) ? cnt_c + CNT_W'(1) : '0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    rot_d     = CMD_ROT;
                    dir_d     = CMD_DIR;
                    count_d   = count_sat_c;
                    data_d    = CMD_DATA;
                    ser_d     = CMD_SER;
                    res_ser_d = '0;
                    if (CMD_LOAD) begin
                        state_d = ST_LOAD;
                    end else if (count_sat_c != '0) begin
                        state_d = ST_SHIFT;
                    end else begin
                        state_d = ST_SETTLE;
                    end
                end
            end
            ST_LOAD:   state_d = (count_q != '0) ? ST_SHIFT : ST_SETTLE;
            ST_SHIFT: begin
                res_ser_d = res_ser_q | ((S_OUT ? ONE_HOT0 : '0) << cnt_c);
                if (last_c) begin
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                res_q_d = Q;
                state_d = ST_REPORT;
            end
            ST_REPORT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_IDLE:   ready_d = HIGH;
            ST_LOAD: begin
                enb_d  = HIGH;
                modo_d = MODO_10;
                d_d    = data_d;
            end
            ST_SHIFT: begin
                enb_d  = HIGH;
                modo_d = shift_modo(rot_d);
                pdir_d = dir_d;
                s_in_d = |(ser_d & (ONE_HOT0 << shift_idx_c));
            end
            ST_REPORT: done_d = HIGH;
            default:   ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            rot_q     <= LOW;
            dir_q     <= LOW;
            count_q   <= '0;
            data_q    <= '0;
            ser_q     <= '0;
            ready_q   <= HIGH;
            enb_q     <= LOW;
            pdir_q    <= LOW;
            s_in_q    <= LOW;
            done_q    <= LOW;
            modo_q    <= MODO_11;
            d_q       <= '0;
            res_q_q   <= '0;
            res_ser_q <= '0;
        end else begin
            state_q   <= state_d;
            rot_q     <= rot_d;
            dir_q     <= dir_d;
            count_q   <= count_d;
            data_q    <= data_d;
            ser_q     <= ser_d;
            ready_q   <= ready_d;
            enb_q     <= enb_d;
            pdir_q    <= pdir_d;
            s_in_q    <= s_in_d;
            done_q    <= done_d;
            modo_q    <= modo_d;
            d_q       <= d_d;
            res_q_q   <= res_q_d;
            res_ser_q <= res_ser_d;
        end
    end

    assign CMD_READY = ready_q;
    assign ENB       = enb_q;
    assign DIR       = pdir_q;
    assign S_IN      = s_in_q;
    assign MODO      = modo_q;
    assign D         = d_q;
    assign DONE      = done_q;
    assign RES_Q     = res_q_q;
    assign RES_SER   = res_ser_q;

endmodule
